// File: rtl/seq_gen.sv
// Serial pattern transmitter: latches a pattern, length, repeat count and gap,
// then shifts the pattern out MSB-first with zero-filled gaps between passes.
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int LW    = 4,
  parameter int CW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [LW-1:0]    len_in,
  input  logic [CW-1:0]    rep_in,
  input  logic [CW-1:0]    gap_in,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [IW-1:0]    r_last_idx;  // len-1, reloaded at the start of every pass
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_pass;
  logic [CW-1:0]    r_gap;
  logic [CW-1:0]    r_gcnt;
  logic             r_seq;
  logic             r_valid;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_len_ok;
  logic [IW-1:0]    w_first_idx;
  logic [IW-1:0]    w_idx_dec;

  assign w_len_ok    = (len_in != '0) && (len_in <= LW'(WIDTH));
  assign w_first_idx = IW'(len_in - LW'(1));
  assign w_idx_dec   = r_idx - IW'(1);

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of every other register, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pat      <= '0;
      r_last_idx <= '0;
      r_idx      <= '0;
      r_pass     <= '0;
      r_gap      <= '0;
      r_gcnt     <= '0;
      r_seq      <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Pulse outputs default low; only the branches that fire them set them.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && w_len_ok) begin
            r_pat      <= pat_in;
            r_last_idx <= w_first_idx;
            r_idx      <= w_first_idx;
            r_pass     <= rep_in;
            r_gap      <= gap_in;
            r_seq      <= pat_in[w_first_idx];
            r_valid    <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_seq   <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_idx != '0) begin
            r_idx <= w_idx_dec;
            r_seq <= r_pat[w_idx_dec];
          end else if (r_pass == '0) begin
            r_seq   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_gap == '0) begin
            r_pass <= r_pass - CW'(1);
            r_idx  <= r_last_idx;
            r_seq  <= r_pat[r_last_idx];
          end else begin
            r_gcnt  <= r_gap - CW'(1);
            r_seq   <= 1'b0;
            r_valid <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_gcnt != '0) begin
            r_gcnt <= r_gcnt - CW'(1);
          end else begin
            r_pass  <= r_pass - CW'(1);
            r_idx   <= r_last_idx;
            r_seq   <= r_pat[r_last_idx];
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign seq_out   = r_seq;
  assign bit_valid = r_valid;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed corner cases plus random transfers
// compared cycle by cycle against an expected-stream model built from the rules.
module tb_seq_gen;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic [3:0] rep_in;
  logic [3:0] gap_in;
  logic       seq_out;
  logic       bit_valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  seq_gen #(.WIDTH(8), .LW(4), .CW(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pat_in   (pat_in),
    .len_in   (len_in),
    .rep_in   (rep_in),
    .gap_in   (gap_in),
    .seq_out  (seq_out),
    .bit_valid(bit_valid),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string t, input logic e_seq, input logic e_val,
                            input logic e_busy, input logic e_ready,
                            input logic e_done, input logic e_err);
    check({t, ".seq_out"},   seq_out,   e_seq);
    check({t, ".bit_valid"}, bit_valid, e_val);
    check({t, ".busy"},      busy,      e_busy);
    check({t, ".ready"},     ready,     e_ready);
    check({t, ".done"},      done,      e_done);
    check({t, ".err"},       err,       e_err);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected line activity for one whole transfer: each entry is {valid, bit}.
  // Also cross-checks its length against the closed-form cycle count.
  task automatic run_xfer(input string t, input logic [7:0] pat, input int len,
                          input int rep, input int gap, input int abort_cyc,
                          input int restart_cyc, input bit abort_with_start);
    logic [1:0] q[$];
    for (int p = 0; p <= rep; p++) begin
      for (int i = len - 1; i >= 0; i--) q.push_back({1'b1, pat[i]});
      if (p < rep) for (int g = 0; g < gap; g++) q.push_back(2'b00);
    end
    check({t, ".model_len"}, q.size(), len * (rep + 1) + gap * rep);

    pat_in = pat;
    len_in = 4'(len);
    rep_in = 4'(rep);
    gap_in = 4'(gap);
    start  = 1'b1;
    abort  = abort_with_start;
    step();
    start  = 1'b0;
    abort  = 1'b0;
    // Scramble the inputs: the transfer must run from its latched copies.
    pat_in = 8'($urandom);
    len_in = 4'($urandom);
    rep_in = 4'($urandom);
    gap_in = 4'($urandom);

    for (int c = 0; c < q.size(); c++) begin
      check_outs($sformatf("%s.c%0d", t, c + 1), q[c][0], q[c][1], 1'b1, 1'b0, 1'b0, 1'b0);
      if (c + 1 == abort_cyc) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs({t, ".aborted"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_outs({t, ".after_abort"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        return;
      end
      if (c + 1 == restart_cyc) begin
        pat_in = 8'hFF;
        len_in = 4'd2;
        start  = 1'b1;
      end
      step();
      start = 1'b0;
    end
    check_outs({t, ".done_cycle"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_outs({t, ".back_idle"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic err_case(input string t, input logic [3:0] len);
    pat_in = 8'hA5;
    len_in = len;
    rep_in = 4'd1;
    gap_in = 4'd1;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check_outs({t, ".pulse"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_outs({t, ".after"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    pat_in = '0;
    len_in = '0;
    rep_in = '0;
    gap_in = '0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    run_xfer("single",  8'b101, 3, 0, 0, -1, -1, 1'b0);
    run_xfer("gapped",  8'b101, 3, 2, 2, -1, -1, 1'b0);
    run_xfer("b2b",     8'b101, 3, 1, 0, -1, -1, 1'b0);
    err_case("len0", 4'd0);
    err_case("len9", 4'd9);
    run_xfer("abort",   8'hC3,  8, 0, 0,  2, -1, 1'b0);
    run_xfer("ign_st",  8'h5A,  8, 0, 0, -1,  3, 1'b0);
    run_xfer("abt_gap", 8'hB1,  4, 2, 3,  6, -1, 1'b0);
    run_xfer("st_abt",  8'h96,  8, 0, 0, -1, -1, 1'b1);
    run_xfer("len1",    8'h01,  1, 3, 0, -1, -1, 1'b0);
    run_xfer("max",     8'h01,  1, 15, 15, -1, -1, 1'b0);
    run_xfer("full",    8'hE7,  8, 1, 1, -1, -1, 1'b0);

    // Reset mid-SEND, then a fresh transfer must behave normally.
    pat_in = 8'hFF;
    len_in = 4'd8;
    rep_in = 4'd0;
    gap_in = 4'd0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer("post_reset", 8'b0110, 4, 1, 2, -1, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_xfer($sformatf("rnd%0d", k), 8'($urandom), int'($urandom_range(1, 8)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1, 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
